// File: rtl/cov_matrix_assembler_pkg.sv
// ---------------------------------------------------------------------------
// cov_matrix_assembler_pkg
//
// Shared definitions for the covariance-matrix assembler and the
// correlator-sequencing logic that feeds it.
//   N_ANT_DEFAULT : default antenna count (matrix dimension)
//   DW_DEFAULT    : default signed width of one real/imag correlation word
//   tri_count()   : number of words in the upper triangle incl. diagonal
//   state_t       : FSM encoding shared with the correlator sequencer
// ---------------------------------------------------------------------------
package cov_matrix_assembler_pkg;

    localparam int N_ANT_DEFAULT = 8;
    localparam int DW_DEFAULT    = 25;

    // Words in an n x n Hermitian upper triangle, diagonal included.
    function automatic int tri_count(input int n);
        return (n * (n + 1)) / 2;
    endfunction

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage

// File: rtl/cov_matrix_assembler_if.sv
// ---------------------------------------------------------------------------
// cov_matrix_assembler_if
//
// Bundles the upstream correlation stream and the downstream matrix stream
// of the assembler.
//   i_valid / i_r / i_c / o_ready        : upstream triangle words
//   o_m_valid / o_m_r / o_m_c / o_m_last : downstream matrix elements
//   i_m_ready                            : downstream acceptance
//   o_busy                               : assembler holds a partial/full matrix
// Modports:
//   slave  : the assembler's view
//   master : the surrounding environment's view
// ---------------------------------------------------------------------------
interface cov_matrix_assembler_if #(
    parameter int DW = cov_matrix_assembler_pkg::DW_DEFAULT
) ();

    logic                 i_valid;
    logic signed [DW-1:0] i_r;
    logic signed [DW-1:0] i_c;
    logic                 o_ready;
    logic                 o_m_valid;
    logic signed [DW-1:0] o_m_r;
    logic signed [DW-1:0] o_m_c;
    logic                 o_m_last;
    logic                 i_m_ready;
    logic                 o_busy;

    modport slave (
        input  i_valid, i_r, i_c, i_m_ready,
        output o_ready, o_m_valid, o_m_r, o_m_c, o_m_last, o_busy
    );

    modport master (
        output i_valid, i_r, i_c, i_m_ready,
        input  o_ready, o_m_valid, o_m_r, o_m_c, o_m_last, o_busy
    );

endinterface

// File: rtl/cov_matrix_assembler_tri_index.sv
// ---------------------------------------------------------------------------
// cov_tri_index
//
// Combinational mapping from a full-matrix position (row, col) to the
// row-major upper-triangle storage index, plus the conjugate select.
//   row, col : matrix coordinates, each in 0..N_ANT-1
//   idx      : triangle index of (min, max) of the coordinates
//   swap     : high below the diagonal, where the stored word must be
//              conjugated before it is emitted
// ---------------------------------------------------------------------------
module cov_tri_index
    import cov_matrix_assembler_pkg::*;
#(
    parameter int N_ANT = N_ANT_DEFAULT,
    localparam int NT = tri_count(N_ANT),
    localparam int RW = (N_ANT > 1) ? $clog2(N_ANT) : 1,
    localparam int IW = (NT > 1) ? $clog2(NT) : 1
) (
    input  logic [RW-1:0] row,
    input  logic [RW-1:0] col,
    output logic [IW-1:0] idx,
    output logic          swap
);

    int lo;
    int hi;
    int flat;

    // Below the diagonal the element is the mirror of (col, row), so the
    // smaller coordinate always selects the triangle row.
    always_comb begin
        swap = (col < row);
        lo   = swap ? int'(col) : int'(row);
        hi   = swap ? int'(row) : int'(col);
        flat = lo * N_ANT - (lo * (lo - 1)) / 2 + (hi - lo);
        idx  = IW'(flat);
    end

endmodule

// File: rtl/cov_matrix_assembler.sv
// ---------------------------------------------------------------------------
// cov_matrix_assembler
//
// Collects the upper triangle of an N_ANT x N_ANT Hermitian covariance
// matrix (row-major, diagonal included) and then emits the full matrix
// row-major, conjugating the mirrored lower-triangle elements.
//   i_clk   : clock, rising edge
//   i_reset : asynchronous, active-low reset
//   bus     : cov_matrix_assembler_if.slave (upstream words, downstream
//             matrix elements, o_busy)
// ---------------------------------------------------------------------------
module cov_matrix_assembler
    import cov_matrix_assembler_pkg::*;
#(
    parameter int N_ANT = N_ANT_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    cov_matrix_assembler_if.slave  bus
);

    localparam int NT = tri_count(N_ANT);
    localparam int RW = (N_ANT > 1) ? $clog2(N_ANT) : 1;
    localparam int IW = (NT > 1) ? $clog2(NT) : 1;

    localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};

    state_t                state;
    state_t                next_state;
    logic [IW-1:0]         k;
    logic [RW-1:0]         row;
    logic [RW-1:0]         col;
    logic [2*DW-1:0]       tri_mem [NT];

    logic                  out_valid;
    logic                  out_last;
    logic signed [DW-1:0]  out_r;
    logic signed [DW-1:0]  out_c;

    logic                  ready;
    logic                  busy;
    logic                  accept;
    logic                  last_word;
    logic                  out_fire;
    logic                  load;
    logic                  load_last;

    logic [IW-1:0]         rd_idx;
    logic                  rd_swap;
    logic [2*DW-1:0]       rd_entry;
    logic signed [DW-1:0]  rd_r;
    logic signed [DW-1:0]  rd_c;
    logic signed [DW-1:0]  elem_c;

    assign accept    = bus.i_valid & ready;
    assign last_word = (k == IW'(NT - 1));
    assign out_fire  = out_valid & bus.i_m_ready;

    // A new element enters the output register on the first EMIT cycle and
    // after every accepted element except the final one.
    assign load      = (state == EMIT) & (~out_valid | (bus.i_m_ready & ~out_last));
    assign load_last = (row == RW'(N_ANT - 1)) & (col == RW'(N_ANT - 1));

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (accept && last_word) next_state = EMIT;
            EMIT:    if (out_fire && out_last) next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ready = 1'b0;
        case (state)
            COLLECT: ready = 1'b1;
            EMIT:    ready = 1'b0;
            default: ready = 1'b0;
        endcase
        busy = (state == EMIT) | (k != '0);
    end

    // Triangle write pointer; wraps to zero on the last word of a matrix.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            k <= '0;
        end else if (accept) begin
            k <= last_word ? '0 : k + IW'(1);
        end
    end

    // Triangle storage deliberately has no reset; it is always fully
    // rewritten before anything is read out.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            tri_mem[k] <= {bus.i_r, bus.i_c};
        end
    end

    // (row, col) points at the next element to be loaded, so it is cleared
    // as soon as the final element has been loaded.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            row <= '0;
            col <= '0;
        end else if (load) begin
            if (load_last) begin
                row <= '0;
                col <= '0;
            end else if (col == RW'(N_ANT - 1)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + RW'(1);
            end
        end
    end

    cov_tri_index #(
        .N_ANT (N_ANT)
    ) u_tri_index (
        .row  (row),
        .col  (col),
        .idx  (rd_idx),
        .swap (rd_swap)
    );

    // Read mux and conjugation; the only negative value without a positive
    // counterpart saturates to the largest positive value.
    always_comb begin
        rd_entry = tri_mem[rd_idx];
        rd_r     = rd_entry[2*DW-1:DW];
        rd_c     = rd_entry[DW-1:0];
        elem_c   = rd_c;
        if (rd_swap) begin
            elem_c = (rd_c == MIN_VAL) ? MAX_VAL : -rd_c;
        end
    end

    // Output register; holds while the downstream stalls.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_r     <= '0;
            out_c     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_last  <= load_last;
            out_r     <= rd_r;
            out_c     <= elem_c;
        end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_busy    = busy;
    assign bus.o_m_valid = out_valid;
    assign bus.o_m_last  = out_last;
    assign bus.o_m_r     = out_r;
    assign bus.o_m_c     = out_c;

endmodule

// File: tb/tb_cov_matrix_assembler.sv
// ---------------------------------------------------------------------------
// tb_cov_matrix_assembler
//
// Directed bench for cov_matrix_assembler at the default size (8 antennas,
// 25-bit words). Feeds triangles, captures the emitted matrix and checks it
// against hand-computed spot values and a small Hermitian model.
// ---------------------------------------------------------------------------
module tb_cov_matrix_assembler;

    localparam int N    = 8;
    localparam int DW   = 25;
    localparam int NT   = 36;
    localparam int NE   = 64;
    localparam int MINV = -(1 << 24);
    localparam int MAXV = (1 << 24) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cov_matrix_assembler_if #(.DW(DW)) bus ();

    cov_matrix_assembler #(
        .N_ANT (N),
        .DW    (DW)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int row;
        int col;
        int exp_r;
        int exp_c;
        bit exp_last;
    } vec_t;

    vec_t vecs [8];

    int compared   = 0;
    int mismatched = 0;

    int tr [NT];
    int tc [NT];
    int got_r [NE];
    int got_c [NE];
    bit got_last [NE];

    int n_hs;
    int first_seen;
    int stall_viol;
    int ready_viol;
    int busy_viol;
    bit track_busy;

    // One comparison: counts it, and reports it if it disagrees.
    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic loadData(input int r_base, input int c_base);
        for (int i = 0; i < NT; i++) begin
            tr[i] = i + r_base;
            tc[i] = i + c_base;
        end
    endtask

    function automatic int triIdx(input int a, input int b);
        return a * N - (a * (a - 1)) / 2 + (b - a);
    endfunction

    function automatic int modelR(input int r, input int c);
        return (c >= r) ? tr[triIdx(r, c)] : tr[triIdx(c, r)];
    endfunction

    function automatic int modelC(input int r, input int c);
        int v;
        if (c >= r) return tc[triIdx(r, c)];
        v = tc[triIdx(c, r)];
        return (v == MINV) ? MAXV : -v;
    endfunction

    // Feeds the NT words in tr/tc, optionally with random valid gaps.
    task automatic applyStimulus(input bit gaps);
        int i   = 0;
        int cyc = 0;
        bit will;
        while (i < NT && cyc < 2000) begin
            @(negedge clk);
            bus.i_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_r     = DW'(tr[i]);
            bus.i_c     = DW'(tc[i]);
            if (track_busy && i > 0 && !bus.o_busy) busy_viol++;
            if (track_busy && i == 0 && bus.o_busy) busy_viol++;
            will = bus.i_valid && bus.o_ready;
            @(posedge clk);
            if (will) i++;
            cyc++;
        end
        checkOutput("accepted_words", i, NT);
    endtask

    // Drains the matrix. stop_after > 0 returns after that many handshakes
    // (the last one still pending at the next rising edge).
    task automatic runEmit(input bit backpressure, input bit junk, input int stop_after);
        int cyc = 0;
        bit done = 1'b0;
        bit prev_stall = 1'b0;
        int pr = 0;
        int pc = 0;
        bit pl = 1'b0;
        bit rdy;
        n_hs = 0;
        first_seen = -1;
        stall_viol = 0;
        ready_viol = 0;
        for (int i = 0; i < NE; i++) begin
            got_r[i] = -999999;
            got_c[i] = -999999;
            got_last[i] = 1'b0;
        end
        while (!done && cyc < 2000) begin
            @(negedge clk);
            rdy = backpressure ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            bus.i_m_ready = rdy;
            if (junk) begin
                bus.i_valid = 1'b1;
                bus.i_r = DW'($urandom);
                bus.i_c = DW'($urandom);
                if (bus.o_ready) ready_viol++;
            end else begin
                bus.i_valid = 1'b0;
            end
            if (track_busy && !bus.o_busy) busy_viol++;
            if (prev_stall && (!bus.o_m_valid || int'(bus.o_m_r) != pr ||
                               int'(bus.o_m_c) != pc || bus.o_m_last != pl)) stall_viol++;
            if (bus.o_m_valid && first_seen < 0) first_seen = cyc;
            if (bus.o_m_valid && rdy) begin
                if (n_hs < NE) begin
                    got_r[n_hs] = int'(bus.o_m_r);
                    got_c[n_hs] = int'(bus.o_m_c);
                    got_last[n_hs] = bus.o_m_last;
                end
                n_hs++;
                if (bus.o_m_last || n_hs == stop_after) done = 1'b1;
            end
            prev_stall = bus.o_m_valid && !rdy;
            pr = int'(bus.o_m_r);
            pc = int'(bus.o_m_c);
            pl = bus.o_m_last;
            cyc++;
        end
    endtask

    task automatic compareMatrix(input string tag);
        int last_err = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                checkOutput($sformatf("%s_r(%0d,%0d)", tag, r, c), got_r[r*N+c], modelR(r, c));
                checkOutput($sformatf("%s_c(%0d,%0d)", tag, r, c), got_c[r*N+c], modelC(r, c));
            end
        end
        for (int i = 0; i < NE; i++) begin
            if (got_last[i] != (i == NE - 1)) last_err++;
        end
        checkOutput($sformatf("%s_last_position", tag), last_err, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.i_valid   = 1'b0;
        bus.i_r       = '0;
        bus.i_c       = '0;
        bus.i_m_ready = 1'b1;
        track_busy    = 1'b0;
        busy_viol     = 0;

        // Spot values for data i_r = k, i_c = k + 100.
        vecs[0] = '{0, 0,  0,  100, 1'b0};
        vecs[1] = '{0, 1,  1,  101, 1'b0};
        vecs[2] = '{1, 0,  1, -101, 1'b0};
        vecs[3] = '{7, 7, 35,  135, 1'b1};
        vecs[4] = '{2, 5, 18,  118, 1'b0};
        vecs[5] = '{5, 2, 18, -118, 1'b0};
        vecs[6] = '{7, 0,  7, -107, 1'b0};
        vecs[7] = '{6, 7, 34,  134, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_m_valid", int'(bus.o_m_valid), 0);
        checkOutput("reset_m_last",  int'(bus.o_m_last), 0);
        checkOutput("reset_m_r",     int'(bus.o_m_r), 0);
        checkOutput("reset_m_c",     int'(bus.o_m_c), 0);
        checkOutput("reset_busy",    int'(bus.o_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_ready", int'(bus.o_ready), 1);

        // Basic collection and full-rate emission.
        $display("[TB] basic matrix");
        loadData(0, 100);
        applyStimulus(1'b0);
        runEmit(1'b0, 1'b0, 0);
        checkOutput("basic_handshakes", n_hs, NE);
        checkOutput("basic_first_valid_latency", first_seen, 1);
        compareMatrix("basic");
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("vec%0d_r", i), got_r[vecs[i].row*N+vecs[i].col], vecs[i].exp_r);
            checkOutput($sformatf("vec%0d_c", i), got_c[vecs[i].row*N+vecs[i].col], vecs[i].exp_c);
            checkOutput($sformatf("vec%0d_last", i), int'(got_last[vecs[i].row*N+vecs[i].col]),
                        int'(vecs[i].exp_last));
        end

        // Downstream backpressure 1,0,0,1.
        $display("[TB] backpressure");
        loadData(0, 100);
        applyStimulus(1'b0);
        runEmit(1'b1, 1'b0, 0);
        checkOutput("bp_handshakes", n_hs, NE);
        checkOutput("bp_stall_stable", stall_viol, 0);
        compareMatrix("bp");

        // Saturating conjugate, with junk upstream traffic during EMIT.
        $display("[TB] saturation and junk input");
        loadData(0, 100);
        tc[1] = MINV;
        applyStimulus(1'b0);
        runEmit(1'b0, 1'b1, 0);
        checkOutput("sat_handshakes", n_hs, NE);
        checkOutput("sat_elem10_c", got_c[8], MAXV);
        checkOutput("sat_elem01_c", got_c[1], MINV);
        checkOutput("junk_ready_low", ready_viol, 0);
        compareMatrix("sat");

        // Fresh collection after junk must start from k = 0.
        $display("[TB] fresh collection");
        loadData(500, -7);
        applyStimulus(1'b0);
        runEmit(1'b0, 1'b0, 0);
        checkOutput("fresh_elem00_r", got_r[0], 500);
        checkOutput("fresh_elem00_c", got_c[0], -7);
        compareMatrix("fresh");

        // Reset in the middle of emission.
        $display("[TB] reset mid-emit");
        loadData(0, 100);
        applyStimulus(1'b0);
        runEmit(1'b0, 1'b0, 20);
        checkOutput("pre_reset_handshakes", n_hs, 20);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_m_valid", int'(bus.o_m_valid), 0);
        checkOutput("midreset_m_last",  int'(bus.o_m_last), 0);
        checkOutput("midreset_m_r",     int'(bus.o_m_r), 0);
        checkOutput("midreset_busy",    int'(bus.o_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midreset_ready", int'(bus.o_ready), 1);
        loadData(1000, 2000);
        applyStimulus(1'b0);
        runEmit(1'b0, 1'b0, 0);
        checkOutput("post_reset_handshakes", n_hs, NE);
        checkOutput("post_reset_elem00_r", got_r[0], 1000);
        compareMatrix("post_reset");

        // Random valid gaps; o_busy must cover the whole transaction.
        $display("[TB] gapped collection");
        loadData(0, 100);
        busy_viol  = 0;
        track_busy = 1'b1;
        applyStimulus(1'b1);
        runEmit(1'b0, 1'b0, 0);
        track_busy = 1'b0;
        checkOutput("gaps_handshakes", n_hs, NE);
        checkOutput("gaps_busy_window", busy_viol, 0);
        compareMatrix("gaps");
        @(negedge clk);
        checkOutput("gaps_busy_after", int'(bus.o_busy), 0);
        checkOutput("gaps_valid_after", int'(bus.o_m_valid), 0);
        checkOutput("gaps_ready_after", int'(bus.o_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cov_matrix_assembler.md
COV_MATRIX_ASSEMBLER -- requirements
Module: cov_matrix_assembler

Interface
REQ-001 Parameter N_ANT, default 8: antenna count, i.e. the matrix dimension.
REQ-002 Parameter DW, default 25: signed width of each real/imag correlation word.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  1  upstream correlation word valid.
REQ-006 i_r  input  DW  signed real part of R(x,y).
REQ-007 i_c  input  DW  signed imag part of R(x,y).
REQ-008 o_ready  output  1  block accepts an upstream word this cycle.
REQ-009 o_m_valid  output  1  matrix output word valid.
REQ-010 o_m_r  output  DW  signed real part of matrix element.
REQ-011 o_m_c  output  DW  signed imag part of matrix element.
REQ-012 o_m_last  output  1  marks element (N_ANT-1, N_ANT-1).
REQ-013 i_m_ready  input  1  downstream accepts the output word.
REQ-014 o_busy  output  1  high in any state other than COLLECT with zero words received.

Function
REQ-015 Input order is fixed: upper triangle including the diagonal, row-major: (0,0),(0,1)..(0,N-1),(1,1)..(N-1,N-1).
  - NT = N_ANT*(N_ANT+1)/2 words, i.e. 36 at the default.
REQ-016 FSM states: COLLECT and EMIT. Reset enters COLLECT.
REQ-017 COLLECT:
  - o_ready = 1.
  - Each word with i_valid & o_ready is stored at triangle index k, and k increments.
REQ-018 On acceptance of word k = NT-1, the next state is EMIT.
  - k clears.
  - o_ready is 0 from the following cycle.
REQ-019 EMIT:
  - o_ready = 0; i_valid is ignored.
  - Outputs the full N_ANT x N_ANT matrix row-major (row r, column c), N_ANT^2 words (64 at the default).
REQ-020 Element rule:
  - c >= r: tri[idx(r,c)].
  - c < r: conj(tri[idx(c,r)]), i.e. the real part unchanged and the imag part negated.
  - idx(r,c) = r*N_ANT - r*(r-1)/2 + (c-r).
REQ-021 Negation saturates: -(-2^(DW-1)) yields 2^(DW-1)-1. No other arithmetic is performed.
REQ-022 Diagonal elements are emitted exactly as stored; the imag part is not forced to zero.
REQ-023 Output is registered:
  - o_m_valid rises the cycle after entering EMIT.
  - Latency from the last accepted input to the first output word is 1 cycle.
REQ-024 Output handshake:
  - o_m_r, o_m_c and o_m_last hold stable while o_m_valid & !i_m_ready.
  - The next element is presented the cycle after each o_m_valid & i_m_ready.
  - Sustained throughput is 1 word per cycle.
REQ-025 o_m_last is asserted only with element (N-1,N-1).
  - On its acceptance: o_m_valid drops next cycle, the state returns to COLLECT, and r, c and k clear.
REQ-026 In EMIT, the (r,c) counters wrap c to 0 and increment r when c = N_ANT-1.
REQ-027 o_busy = (state == EMIT) | (k != 0).

Reset
REQ-028 i_reset low, at any time including mid-COLLECT or mid-EMIT, immediately sets:
  - state = COLLECT; k, r, c = 0.
  - o_m_valid, o_m_last = 0; o_m_r, o_m_c = 0.
  - o_ready = 1 once reset deasserts.
REQ-029 Triangle storage is not reset. Its contents are undefined until rewritten and are never emitted before a complete collection.

Structure
REQ-030 Shared package holds:
  - N_ANT and DW defaults.
  - The NT constant function.
  - The FSM state encoding {COLLECT, EMIT}, shared with the correlator-sequencing logic.
REQ-031 One sub-module, cov_tri_index: combinational (r,c) -> idx mapping plus the swap/conjugate select, unit-testable on its own.
REQ-032 Storage is an NT-entry register array of 2*DW bits (no RAM macro), with a combinational read mux feeding the output register.

Verification
REQ-033 Feed 36 words, i_r = k, i_c = k+100, continuous valid, i_m_ready = 1.
  - Required: 64 outputs follow.
  - (0,1) = (1,101); (1,0) = (1,-101); (7,7) = (35,135) with o_m_last = 1.
  - First o_m_valid 1 cycle after the 36th accept.
REQ-034 Backpressure: toggle i_m_ready 1,0,0,1 during EMIT.
  - Required: data stable while stalled, no element dropped or duplicated, exactly 64 handshakes.
REQ-035 Word k = 1 with i_c = -2^24.
  - Required: element (1,0) imag = 2^24-1; element (0,1) imag = -2^24.
REQ-036 i_valid asserted during EMIT with junk data.
  - Required: o_ready = 0, junk ignored, next collection stores fresh data from k = 0.
REQ-037 Assert reset after the 20th output word, then run a fresh 36-word collection.
  - Required: o_m_valid = 0 immediately; the new matrix emits from (0,0) with the new data.
REQ-038 Random i_valid gaps during COLLECT (roughly 50% duty).
  - Required: the same matrix as in REQ-033; o_busy high from the first accept until the last output is accepted.
